// File: rtl/uart_fifo_core.sv
// uart_fifo_core: 8x-oversampled UART with runtime baud divisor, TX/RX FIFOs and sticky error flags.
// Optional parity bit in both directions is enabled by defining UART_PARITY_EN.

module uart_fifo_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

module uart_fifo_core #(
   parameter int SYS_CLK_FREQ = 100_000_000,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic [15:0]          baud_div,
   input  logic                 tx_wr,
   input  logic [DATA_BITS-1:0] tx_wdata,
   output logic                 tx_full,
   output logic                 tx_idle,
   output logic                 tx_data,
   input  logic                 rx_data,
   input  logic                 rx_rd,
   output logic [DATA_BITS-1:0] rx_rdata,
   output logic                 rx_valid,
   input  logic                 parity_odd,
   input  logic                 err_clr,
   output logic                 overrun_err,
   output logic                 frame_err,
   output logic                 parity_err
);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, parity_odd, (SYS_CLK_FREQ != 0)};

   // Oversample tick; the divisor is latched only at wrap so a change never truncates a tick.
   logic [15:0] r_tick_cnt;
   logic [15:0] r_div;
   logic [15:0] w_div_eff;
   logic        w_tick;

   assign w_div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
   assign w_tick    = (r_tick_cnt == r_div - 16'd1);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_div      <= 16'd1;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
         r_div      <= w_div_eff;
      end else begin
         r_tick_cnt <= r_tick_cnt + 16'd1;
      end
   end

   logic                 w_tx_pop;
   logic                 w_tx_empty;
   logic [DATA_BITS-1:0] w_tx_head;

   uart_fifo_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk      (sys_clk),
      .i_rst      (rst),
      .i_push     (tx_wr),
      .i_push_dat (tx_wdata),
      .i_pop      (w_tx_pop),
      .o_head     (w_tx_head),
      .o_full     (tx_full),
      .o_empty    (w_tx_empty)
   );

   tx_state_t            r_tx_state, w_tx_state_nxt;
   logic [2:0]           r_tx_tcnt, w_tx_tcnt_nxt;
   logic [2:0]           r_tx_bit, w_tx_bit_nxt;
   logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
   logic                 w_tx_line;
`ifdef UART_PARITY_EN
   logic                 r_tx_par, w_tx_par_nxt;
`endif

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_tcnt  <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
`ifdef UART_PARITY_EN
         r_tx_par   <= 1'b0;
`endif
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_tcnt  <= w_tx_tcnt_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx_shift <= w_tx_shift_nxt;
`ifdef UART_PARITY_EN
         r_tx_par   <= w_tx_par_nxt;
`endif
      end
   end

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_tcnt_nxt  = r_tx_tcnt;
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_pop       = 1'b0;
`ifdef UART_PARITY_EN
      w_tx_par_nxt   = r_tx_par;
`endif
      if (w_tick) begin
         w_tx_tcnt_nxt = r_tx_tcnt + 3'd1;
         case (r_tx_state)
            TX_IDLE: begin
               w_tx_tcnt_nxt = 3'd0;
               if (!w_tx_empty) begin
                  w_tx_pop       = 1'b1;
                  w_tx_state_nxt = TX_START;
               end
            end
            TX_START: if (r_tx_tcnt == 3'd7) w_tx_state_nxt = TX_DATA;
            TX_DATA: if (r_tx_tcnt == 3'd7) begin
               w_tx_shift_nxt = r_tx_shift >> 1;
               w_tx_bit_nxt   = r_tx_bit + 3'd1;
               if (r_tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                  w_tx_state_nxt = TX_PAR;
`else
                  w_tx_state_nxt = TX_STOP;
`endif
               end
            end
            TX_PAR: if (r_tx_tcnt == 3'd7) w_tx_state_nxt = TX_STOP;
            TX_STOP: if (r_tx_tcnt == 3'd7) begin
               // Chain straight into the next start bit when more data is queued.
               if (!w_tx_empty) begin
                  w_tx_pop       = 1'b1;
                  w_tx_state_nxt = TX_START;
               end else begin
                  w_tx_state_nxt = TX_IDLE;
               end
            end
            default: w_tx_state_nxt = TX_IDLE;
         endcase
         if (w_tx_pop) begin
            w_tx_shift_nxt = w_tx_head;
            w_tx_bit_nxt   = 3'd0;
`ifdef UART_PARITY_EN
            w_tx_par_nxt   = (^w_tx_head) ^ parity_odd;
`endif
         end
      end
   end

   always_comb begin
      w_tx_line = 1'b1;
      case (r_tx_state)
         TX_START: w_tx_line = 1'b0;
         TX_DATA:  w_tx_line = r_tx_shift[0];
`ifdef UART_PARITY_EN
         TX_PAR:   w_tx_line = r_tx_par;
`endif
         default:  w_tx_line = 1'b1;
      endcase
   end

   assign tx_data = w_tx_line;
   assign tx_idle = w_tx_empty & (r_tx_state == TX_IDLE);

   logic                 r_rx_s1, r_rx_s2;
   rx_state_t            r_rx_state, w_rx_state_nxt;
   logic [2:0]           r_rx_tcnt, w_rx_tcnt_nxt;
   logic [2:0]           r_rx_bit, w_rx_bit_nxt;
   logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
   logic                 w_rx_push;
   logic                 w_rx_full;
   logic                 w_rx_empty;
   logic                 w_frame_set;
   logic                 w_par_set;
   logic                 r_overrun, r_frame;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_tcnt  <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_s1    <= rx_data;
         r_rx_s2    <= r_rx_s1;
         r_rx_state <= w_rx_state_nxt;
         r_rx_tcnt  <= w_rx_tcnt_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_shift <= w_rx_shift_nxt;
      end
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_tcnt_nxt  = r_rx_tcnt;
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_push      = 1'b0;
      w_frame_set    = 1'b0;
      w_par_set      = 1'b0;
      if (w_tick) begin
         w_rx_tcnt_nxt = r_rx_tcnt + 3'd1;
         case (r_rx_state)
            RX_IDLE: begin
               w_rx_tcnt_nxt = 3'd0;
               if (!r_rx_s2) w_rx_state_nxt = RX_START;
            end
            // Half a bit in: a line back high means the start edge was a glitch.
            RX_START: if (r_rx_tcnt == 3'd3) begin
               w_rx_tcnt_nxt  = 3'd0;
               w_rx_bit_nxt   = 3'd0;
               w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (r_rx_tcnt == 3'd7) begin
               w_rx_shift_nxt = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
               w_rx_bit_nxt   = r_rx_bit + 3'd1;
               if (r_rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                  w_rx_state_nxt = RX_PAR;
`else
                  w_rx_state_nxt = RX_STOP;
`endif
               end
            end
`ifdef UART_PARITY_EN
            RX_PAR: if (r_rx_tcnt == 3'd7) begin
               w_par_set      = ((^r_rx_shift) ^ parity_odd) != r_rx_s2;
               w_rx_state_nxt = RX_STOP;
            end
`endif
            RX_STOP: if (r_rx_tcnt == 3'd7) begin
               w_rx_push      = 1'b1;
               w_frame_set    = ~r_rx_s2;
               w_rx_state_nxt = RX_IDLE;
            end
            default: w_rx_state_nxt = RX_IDLE;
         endcase
      end
   end

   uart_fifo_sync_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk      (sys_clk),
      .i_rst      (rst),
      .i_push     (w_rx_push),
      .i_push_dat (r_rx_shift),
      .i_pop      (rx_rd),
      .o_head     (rx_rdata),
      .o_full     (w_rx_full),
      .o_empty    (w_rx_empty)
   );

   assign rx_valid = ~w_rx_empty;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_overrun <= 1'b0;
         r_frame   <= 1'b0;
      end else begin
         r_overrun <= (r_overrun & ~err_clr) | (w_rx_push & w_rx_full);
         r_frame   <= (r_frame & ~err_clr) | w_frame_set;
      end
   end

   assign overrun_err = r_overrun;
   assign frame_err   = r_frame;

`ifdef UART_PARITY_EN
   logic r_parity;
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) r_parity <= 1'b0;
      else     r_parity <= (r_parity & ~err_clr) | w_par_set;
   end
   assign parity_err = r_parity;
`else
   logic w_unused_par;
   assign w_unused_par = w_par_set;
   assign parity_err   = 1'b0;
`endif
endmodule
